// File: rtl/prio_resolver_tree.sv
// Per-lane priority resolver: NUM_PIPES candidate rules reduced through a registered
// binary comparison tree, with winning pipe index and a saturating hit counter.
module prio_resolver_tree #(
  parameter  int NUM_PIPES   = 4,
  parameter  int NUM_LANES   = 2,
  parameter  int RULE_ID     = 14,
  parameter  int HIGHER_WINS = 1,
  parameter  int CNT_WIDTH   = 16,
  localparam int LEVELS      = $clog2(NUM_PIPES),
  localparam int PIDX_W      = (LEVELS > 1) ? LEVELS : 1
) (
  input  logic                                 clk,
  input  logic                                 RSTn,
  input  logic [NUM_LANES-1:0]                 valid_in,
  input  logic [NUM_LANES*NUM_PIPES*RULE_ID-1:0] rule_in,
  input  logic [NUM_LANES*NUM_PIPES-1:0]       act_valid_in,
  input  logic                                 cnt_clr,
  output logic [NUM_LANES*RULE_ID-1:0]         rule_id_out,
  output logic [NUM_LANES*PIDX_W-1:0]          pipe_idx_out,
  output logic [NUM_LANES-1:0]                 data_valid_out,
  output logic [NUM_LANES-1:0]                 action_valid_out,
  output logic [NUM_LANES*CNT_WIDTH-1:0]       hit_cnt
);

  localparam int LEAVES = 1 << LEVELS;

  typedef struct packed {
    logic              cand;
    logic [PIDX_W-1:0] idx;
    logic [RULE_ID-1:0] rule;
  } node_t;

  // Left side wins ties so equal rules resolve to the lowest pipe index.
  function automatic node_t pick(input node_t a, input node_t b);
    node_t r;
    r = '0;
    if (a.cand && b.cand) begin
      if (HIGHER_WINS != 0) r = (a.rule >= b.rule) ? a : b;
      else                  r = (a.rule <= b.rule) ? a : b;
    end else if (a.cand) begin
      r = a;
    end else if (b.cand) begin
      r = b;
    end
    return r;
  endfunction

  node_t                leaf   [NUM_LANES][LEAVES];
  node_t                node_d [NUM_LANES][1:LEAVES-1];
  node_t                node_q [NUM_LANES][1:LEAVES-1];
  logic [NUM_LANES-1:0] dv_q   [LEVELS];
  logic [CNT_WIDTH-1:0] cnt_q  [NUM_LANES];

  // Heap layout: node n has children 2n and 2n+1; indices >= LEAVES are leaves.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    for (genvar p = 0; p < LEAVES; p++) begin : g_leaf
      if (p < NUM_PIPES) begin : g_real
        assign leaf[l][p] = {valid_in[l] & act_valid_in[l*NUM_PIPES+p], PIDX_W'(p),
                             rule_in[(l*NUM_PIPES+p)*RULE_ID +: RULE_ID]};
      end else begin : g_pad
        assign leaf[l][p] = '0;
      end
    end

    for (genvar n = 1; n < LEAVES; n++) begin : g_node
      if (2*n >= LEAVES) begin : g_bottom
        assign node_d[l][n] = pick(leaf[l][2*n-LEAVES], leaf[l][2*n+1-LEAVES]);
      end else begin : g_inner
        assign node_d[l][n] = pick(node_q[l][2*n], node_q[l][2*n+1]);
      end
    end

    assign rule_id_out[l*RULE_ID +: RULE_ID]     = node_q[l][1].rule;
    assign pipe_idx_out[l*PIDX_W +: PIDX_W]      = node_q[l][1].idx;
    assign action_valid_out[l]                   = node_q[l][1].cand;
    assign hit_cnt[l*CNT_WIDTH +: CNT_WIDTH]     = cnt_q[l];
  end

  assign data_valid_out = dv_q[LEVELS-1];

  always_ff @(posedge clk) begin
    if (!RSTn) begin
      for (int l = 0; l < NUM_LANES; l++)
        for (int n = 1; n < LEAVES; n++)
          node_q[l][n] <= '0;
      for (int i = 0; i < LEVELS; i++)
        dv_q[i] <= '0;
    end else begin
      node_q <= node_d;
      dv_q[0] <= valid_in;
      for (int i = 1; i < LEVELS; i++)
        dv_q[i] <= dv_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!RSTn) begin
      for (int l = 0; l < NUM_LANES; l++)
        cnt_q[l] <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (cnt_clr)
          cnt_q[l] <= '0;
        else if (dv_q[LEVELS-1][l] && node_q[l][1].cand && (cnt_q[l] != '1))
          cnt_q[l] <= cnt_q[l] + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_prio_resolver_tree.sv
// Scoreboard bench: a max-mode 4-pipe instance and a min-mode 3-pipe instance,
// expectations queued at issue time and popped by negedge monitors.
module tb_prio_resolver_tree;
  localparam int NL = 2, RW = 14, PW = 2;
  localparam int NPA = 4, CWA = 4;
  localparam int NPB = 3, CWB = 16;

  logic clk = 1'b0;
  logic RSTn = 1'b0;
  always #5 clk = ~clk;

  logic [NL-1:0]        valid_a, dv_a, av_a;
  logic [NL*NPA*RW-1:0] rule_a;
  logic [NL*NPA-1:0]    act_a;
  logic                 clr_a;
  logic [NL*RW-1:0]     rid_a;
  logic [NL*PW-1:0]     pidx_a;
  logic [NL*CWA-1:0]    hit_a;

  logic [NL-1:0]        valid_b, dv_b, av_b;
  logic [NL*NPB*RW-1:0] rule_b;
  logic [NL*NPB-1:0]    act_b;
  logic                 clr_b;
  logic [NL*RW-1:0]     rid_b;
  logic [NL*PW-1:0]     pidx_b;
  logic [NL*CWB-1:0]    hit_b;

  prio_resolver_tree #(.NUM_PIPES(NPA), .NUM_LANES(NL), .RULE_ID(RW), .HIGHER_WINS(1),
                       .CNT_WIDTH(CWA)) dut_a (
    .clk(clk), .RSTn(RSTn), .valid_in(valid_a), .rule_in(rule_a), .act_valid_in(act_a),
    .cnt_clr(clr_a), .rule_id_out(rid_a), .pipe_idx_out(pidx_a), .data_valid_out(dv_a),
    .action_valid_out(av_a), .hit_cnt(hit_a));

  prio_resolver_tree #(.NUM_PIPES(NPB), .NUM_LANES(NL), .RULE_ID(RW), .HIGHER_WINS(0),
                       .CNT_WIDTH(CWB)) dut_b (
    .clk(clk), .RSTn(RSTn), .valid_in(valid_b), .rule_in(rule_b), .act_valid_in(act_b),
    .cnt_clr(clr_b), .rule_id_out(rid_b), .pipe_idx_out(pidx_b), .data_valid_out(dv_b),
    .action_valid_out(av_b), .hit_cnt(hit_b));

  typedef struct {
    int rule;
    int idx;
    bit av;
    int at;
  } exp_t;

  exp_t qa0[$], qa1[$], qb0[$], qb1[$];
  int checks = 0, failures = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic cmp(input string tag, input bit dv, input bit av, input int rule,
                     input int idx, input bit have, input exp_t e);
    if (dv) begin
      if (!have) chk({tag, " unexpected output"}, 1, 0);
      else begin
        chk({tag, " rule"}, rule, e.rule);
        chk({tag, " pipe_idx"}, idx, e.idx);
        chk({tag, " action_valid"}, int'(av), int'(e.av));
        chk({tag, " arrival cycle"}, cyc, e.at);
      end
    end else begin
      chk({tag, " idle action_valid"}, int'(av), 0);
      chk({tag, " idle rule"}, rule, 0);
      chk({tag, " idle pipe_idx"}, idx, 0);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit h;
    h = dv_a[0] && (qa0.size() > 0);
    if (h) e = qa0.pop_front();
    cmp("a lane0", dv_a[0], av_a[0], int'(rid_a[0 +: RW]), int'(pidx_a[0 +: PW]), h, e);
    h = dv_a[1] && (qa1.size() > 0);
    if (h) e = qa1.pop_front();
    cmp("a lane1", dv_a[1], av_a[1], int'(rid_a[RW +: RW]), int'(pidx_a[PW +: PW]), h, e);
    h = dv_b[0] && (qb0.size() > 0);
    if (h) e = qb0.pop_front();
    cmp("b lane0", dv_b[0], av_b[0], int'(rid_b[0 +: RW]), int'(pidx_b[0 +: PW]), h, e);
    h = dv_b[1] && (qb1.size() > 0);
    if (h) e = qb1.pop_front();
    cmp("b lane1", dv_b[1], av_b[1], int'(rid_b[RW +: RW]), int'(pidx_b[PW +: PW]), h, e);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    valid_a = '0; rule_a = '0; act_a = '0;
  endtask

  task automatic idle_b();
    valid_b = '0; rule_b = '0; act_b = '0;
  endtask

  task automatic rnd_a();
    logic [127:0] t;
    logic [31:0]  u;
    t = {$urandom, $urandom, $urandom, $urandom};
    u = $urandom;
    rule_a  = t[NL*NPA*RW-1:0];
    act_a   = u[7:0];
    valid_a = u[9:8];
  endtask

  task automatic issue_a(input int l, input int r0, input int r1, input int r2, input int r3,
                         input logic [3:0] act, input bit v, input bit push,
                         input int er, input int ei, input bit eav);
    exp_t e;
    rule_a[(l*NPA+0)*RW +: RW] = RW'(r0);
    rule_a[(l*NPA+1)*RW +: RW] = RW'(r1);
    rule_a[(l*NPA+2)*RW +: RW] = RW'(r2);
    rule_a[(l*NPA+3)*RW +: RW] = RW'(r3);
    act_a[l*NPA +: NPA] = act;
    valid_a[l] = v;
    if (push) begin
      e = '{er, ei, eav, cyc + 2};
      if (l == 0) qa0.push_back(e); else qa1.push_back(e);
    end
  endtask

  task automatic issue_b(input int l, input int r0, input int r1, input int r2,
                         input logic [2:0] act, input bit v, input bit push,
                         input int er, input int ei, input bit eav);
    exp_t e;
    rule_b[(l*NPB+0)*RW +: RW] = RW'(r0);
    rule_b[(l*NPB+1)*RW +: RW] = RW'(r1);
    rule_b[(l*NPB+2)*RW +: RW] = RW'(r2);
    act_b[l*NPB +: NPB] = act;
    valid_b[l] = v;
    if (push) begin
      e = '{er, ei, eav, cyc + 2};
      if (l == 0) qb0.push_back(e); else qb1.push_back(e);
    end
  endtask

  initial begin
    RSTn = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    idle_a(); idle_b();

    // reset hold with random traffic
    repeat (3) begin rnd_a(); tick(); end
    chk("reset action_valid", int'(av_a), 0);
    chk("reset data_valid", int'(dv_a), 0);
    chk("reset rule_id", int'(rid_a), 0);
    chk("reset hit_cnt", int'(hit_a), 0);
    idle_a(); RSTn = 1'b1;
    repeat (4) tick();
    chk("post-reset hit_cnt", int'(hit_a), 0);

    // max select, zero-rule candidate
    idle_a();
    issue_a(0, 5, 900, 17, 899, 4'b1111, 1, 1, 900, 1, 1);
    issue_a(1, 0, 0, 0, 0, 4'b1000, 1, 1, 0, 3, 1);
    tick();
    // ties and masking
    idle_a();
    issue_a(0, 300, 300, 300, 10, 4'b1011, 1, 1, 300, 0, 1);
    issue_a(1, 16383, 1, 16383, 2, 4'b1111, 1, 1, 16383, 0, 1);
    tick();
    idle_a();
    issue_a(0, 300, 300, 300, 10, 4'b0000, 1, 1, 0, 0, 0);
    issue_a(1, 50, 60, 70, 80, 4'b0110, 1, 1, 70, 2, 1);
    tick();
    idle_a();
    issue_a(0, 300, 300, 300, 10, 4'b1111, 0, 0, 0, 0, 0);
    issue_a(1, 9, 8, 7, 6, 4'b1111, 0, 0, 0, 0, 0);
    tick();
    idle_a();
    repeat (3) tick();
    chk("a hit lane0", int'(hit_a[0 +: CWA]), 2);
    chk("a hit lane1", int'(hit_a[CWA +: CWA]), 3);

    // min mode, back-to-back
    idle_b();
    issue_b(0, 7, 3, 9, 3'b111, 1, 1, 3, 1, 1);
    issue_b(1, 5, 5, 1, 3'b011, 1, 1, 5, 0, 1);
    tick();
    idle_b();
    issue_b(0, 0, 4, 2, 3'b111, 1, 1, 0, 0, 1);
    issue_b(1, 0, 0, 0, 3'b100, 1, 1, 0, 2, 1);
    tick();
    idle_b();
    repeat (3) tick();
    chk("b hit lane0", int'(hit_b[0 +: CWB]), 2);
    chk("b hit lane1", int'(hit_b[CWB +: CWB]), 2);

    // counter clear, saturation and lane independence
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    chk("clr lane0", int'(hit_a[0 +: CWA]), 0);
    chk("clr lane1", int'(hit_a[CWA +: CWA]), 0);
    repeat (20) begin
      idle_a();
      issue_a(1, 1, 2, 3, 4, 4'b1111, 1, 1, 4, 3, 1);
      tick();
    end
    idle_a();
    repeat (3) tick();
    chk("sat lane1", int'(hit_a[CWA +: CWA]), 15);
    chk("sat lane0 untouched", int'(hit_a[0 +: CWA]), 0);
    repeat (2) tick();
    chk("sat hold lane1", int'(hit_a[CWA +: CWA]), 15);

    issue_a(1, 1, 2, 3, 4, 4'b1111, 1, 1, 4, 3, 1);
    tick();
    idle_a();
    tick();
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    chk("clr over hit", int'(hit_a[CWA +: CWA]), 0);
    tick();
    chk("clr stays", int'(hit_a[CWA +: CWA]), 0);
    issue_a(1, 1, 2, 3, 4, 4'b1111, 1, 1, 4, 3, 1);
    tick();
    idle_a();
    repeat (3) tick();
    chk("inc after clr", int'(hit_a[CWA +: CWA]), 1);

    // mid-flight reset discards in-flight hits
    issue_a(0, 11, 22, 33, 44, 4'b1111, 1, 0, 0, 0, 0);
    tick();
    idle_a();
    issue_a(0, 11, 22, 33, 44, 4'b1111, 1, 0, 0, 0, 0);
    RSTn = 1'b0;
    tick();
    RSTn = 1'b1;
    idle_a();
    repeat (5) tick();
    chk("midreset hit_cnt", int'(hit_a), 0);
    chk("midreset action_valid", int'(av_a), 0);

    chk("queue a0 drained", qa0.size(), 0);
    chk("queue a1 drained", qa1.size(), 0);
    chk("queue b0 drained", qb0.size(), 0);
    chk("queue b1 drained", qb1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
